updn_cnt_sched: RTL and testbench
=================================

UPDN_CNT_SCHED -- requirements
Module: updn_cnt_sched

Interface
REQ-001 SHALL take parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 SHALL take parameter NREQ, default 2, giving the number of requesters (fixed at 2 for this revision).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester command valid.
REQ-006 req_ready  output  NREQ  per-requester command accepted this cycle.
REQ-007 req_dir  input  NREQ  per-requester direction: 1=up, 0=down.
REQ-008 req_start  input  NREQ*WIDTH  per-requester load value; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_steps  input  NREQ*WIDTH  per-requester step count, packed the same way.
REQ-010 pause  input  1  freezes counting while in RUN.
REQ-011 count  output  WIDTH  shared counter value.
REQ-012 busy  output  1  high in every state other than IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 done_id  output  1  index of the requester whose command completed; valid only when done=1.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-016 In IDLE, SHALL grant at most one valid requester per cycle using round-robin: on contention, grant the requester not granted most recently.
REQ-017 req_ready[i] SHALL be combinational: state==IDLE && grant==i; all other ready bits 0; all ready bits 0 outside IDLE.
REQ-018 On the accept edge (valid&&ready), SHALL register dir, start, steps and the requester id, update the round-robin pointer, and go to LOAD.
REQ-019 LOAD lasts 1 cycle and SHALL set count=start at the end of the cycle; next state is RUN if steps!=0, else DONE.
REQ-020 In RUN, each cycle with pause=0 SHALL step count by +1 (up) or -1 (down) and decrement the remaining steps; a cycle with pause=1 holds count and the remaining steps.
REQ-021 When the final step executes, SHALL go to DONE; RUN therefore lasts exactly steps unpaused cycles.
REQ-022 DONE lasts 1 cycle with done=1 and done_id=id, count holding its final value; next state is IDLE.
REQ-023 Count arithmetic SHALL be modulo 2^WIDTH (15+1 -> 0, 0-1 -> 15); there is no saturation or overflow flag.
REQ-024 count SHALL hold its value in IDLE between commands.
REQ-025 Requests arriving while busy are not accepted; the requester SHALL hold valid and data stable until it sees ready.
REQ-026 A request deasserted before acceptance SHALL be dropped without effect.
REQ-027 pause in LOAD, DONE or IDLE SHALL have no effect.

Reset
REQ-028 With rst=1 at a rising edge, SHALL set state=IDLE, count=0, busy=0, done=0, done_id=0 and the round-robin pointer so that requester 0 wins the first contention.
REQ-029 rst mid-operation (LOAD/RUN/DONE) SHALL abort the command with no done pulse; rst SHALL take priority over accept, pause and stepping.

Structure
REQ-030 Package updn_sched_pkg SHALL hold: the state enum typedef (IDLE, LOAD, RUN, DONE), constants DIR_UP=1 and DIR_DOWN=0, and the WIDTH default.
REQ-031 The counter datapath SHALL be the sub-module updn_counter_core (inputs clk, rst, load, load_val, en, dir; output count), instantiated once.
REQ-032 The arbiter, the FSM and the remaining-step register SHALL reside in updn_cnt_sched.

Verification (WIDTH=4)
REQ-033 req0: up, start=3, steps=4 -> ready0 on cycle 0; count 3 after LOAD, then 4,5,6,7; done=1, done_id=0 one cycle after count=7; busy high for 6 cycles.
REQ-034 req1: up, start=14, steps=3 -> count 14,15,0,1; done_id=1; a following down command with start=1, steps=3 -> count 1,0,15,14.
REQ-035 Both valid from reset -> req0 served first, then req1; with both held valid, service alternates 0,1,0,1.
REQ-036 steps=0, start=9 -> LOAD then DONE; count=9; done pulses on the cycle after LOAD.
REQ-037 pause=1 for 3 cycles mid-RUN in a 5-step up command from start=0 -> count frozen during the pause; final count 5; done delayed 3 cycles.
REQ-038 rst asserted during RUN (count=6) -> next cycle count=0, busy=0, no done pulse; a new request is accepted the cycle after rst drops.

Source files
------------

// File: rtl/updn_sched_pkg.sv
// Shared types and constants for the two-requester up/down counter scheduler.
package updn_sched_pkg;

   localparam int WIDTH_DEF = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/updn_counter_core.sv
// Loadable modulo-2^WIDTH up/down counter; load wins over enable.
module updn_counter_core
   import updn_sched_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en) begin
         r_count <= (dir == DIR_UP) ? r_count + 1'b1 : r_count - 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/updn_cnt_sched.sv
// Round-robin scheduler granting one of two requesters a shared up/down counting run.
module updn_cnt_sched
   import updn_sched_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREQ  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_dir,
   input  logic [NREQ*WIDTH-1:0] req_start,
   input  logic [NREQ*WIDTH-1:0] req_steps,
   input  logic                  pause,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  done,
   output logic                  done_id
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_last;
   logic             r_id;
   logic             r_dir;
   logic [WIDTH-1:0] r_start;
   logic [WIDTH-1:0] r_rem;

   logic             w_grant;
   logic             w_accept;
   logic             w_sel_dir;
   logic [WIDTH-1:0] w_sel_start;
   logic [WIDTH-1:0] w_sel_steps;
   logic             w_load;
   logic             w_en;

   // r_last holds the most recent grant; on contention the other requester wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_grant = req_valid[1];
      if (req_valid[0] && req_valid[1]) begin
         w_grant = ~r_last;
      end
   end

   assign w_accept = (r_state == IDLE) && (|req_valid);

   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_grant] = 1'b1;
      end
   end

   always_comb begin
      w_sel_dir   = req_dir[0];
      w_sel_start = req_start[0 +: WIDTH];
      w_sel_steps = req_steps[0 +: WIDTH];
      if (w_grant) begin
         w_sel_dir   = req_dir[1];
         w_sel_start = req_start[WIDTH +: WIDTH];
         w_sel_steps = req_steps[WIDTH +: WIDTH];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_nxt = LOAD;
         LOAD: w_state_nxt = (r_rem != '0) ? RUN : DONE;
         RUN:  if (!pause && (r_rem == WIDTH'(1))) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_load = (r_state == LOAD);
   assign w_en   = (r_state == RUN) && !pause;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_dir   <= DIR_DOWN;
         r_start <= '0;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_last  <= w_grant;
            r_id    <= w_grant;
            r_dir   <= w_sel_dir;
            r_start <= w_sel_start;
            r_rem   <= w_sel_steps;
         end else if (w_en) begin
            r_rem <= r_rem - 1'b1;
         end
      end
   end

   updn_counter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (r_start),
      .en       (w_en),
      .dir      (r_dir),
      .count    (count)
   );

   assign busy    = (r_state != IDLE);
   assign done    = (r_state == DONE);
   assign done_id = done ? r_id : 1'b0;

endmodule

// File: tb/tb_updn_cnt_sched.sv
// Directed bench for updn_cnt_sched with a per-cycle command-level reference model.
module tb_updn_cnt_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] req_dir;
   logic [7:0] req_start;
   logic [7:0] req_steps;
   logic       pause;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       done_id;

   always #5 clk = ~clk;

   updn_cnt_sched #(.WIDTH(4), .NREQ(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_dir   (req_dir),
      .req_start (req_start),
      .req_steps (req_steps),
      .pause     (pause),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a command is busy for one load cycle, then consumes one
   // step per unpaused cycle, then spends one cycle reporting completion.
   bit       m_ok = 1'b0;
   bit       m_busy, m_load, m_fin, m_dir, m_id, m_last;
   int       m_work;
   int       m_count;
   int       m_start;

   function automatic bit m_grant();
      if (req_valid == 2'b11) return !m_last;
      return req_valid[1];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ok = 1'b1; m_busy = 0; m_load = 0; m_fin = 0;
         m_work = 0; m_count = 0; m_last = 1; m_id = 0; m_dir = 0; m_start = 0;
      end else if (m_ok) begin
         if (!m_busy) begin
            if (req_valid != 2'b00) begin
               m_id    = m_grant();
               m_last  = m_id;
               m_dir   = req_dir[m_id];
               m_start = int'(req_start[m_id*4 +: 4]);
               m_work  = int'(req_steps[m_id*4 +: 4]);
               m_busy  = 1; m_load = 1;
            end
         end else if (m_load) begin
            m_load  = 0;
            m_count = m_start;
            if (m_work == 0) m_fin = 1;
         end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
         end else if (!pause) begin
            m_count = (m_count + (m_dir ? 1 : 15)) % 16;
            m_work--;
            if (m_work == 0) m_fin = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         check("busy", busy, m_busy);
         check("count", count, m_count);
         check("done", done, m_busy && m_fin);
         check("ready", req_ready,
               (!m_busy && req_valid != 2'b00) ? (32'd1 << m_grant()) : 32'd0);
         if (m_busy && m_fin) check("done_id", done_id, m_id);
      end
   end

   task automatic issue(input int id, input bit dir, input int start, input int steps,
                        output int waited);
      req_dir[id]          = dir;
      req_start[id*4 +: 4] = 4'(start);
      req_steps[id*4 +: 4] = 4'(steps);
      req_valid[id]        = 1'b1;
      waited = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            waited = k;
            t_acc  = cyc;
            break;
         end
      end
      if (waited < 0) check("accept_timeout", req_ready[id], 1);
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
   endtask

   task automatic wait_done(output int d_id, output int fin_count, output int nbusy);
      nbusy = -1; d_id = -1; fin_count = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            d_id      = int'(done_id);
            fin_count = int'(count);
            nbusy     = cyc - t_acc;
            break;
         end
      end
      if (nbusy < 0) check("done_timeout", done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, id, cnt, nb;
      int order [4];
      rst = 1; req_valid = 0; req_dir = 0; req_start = 0; req_steps = 0; pause = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_done_id", done_id, 0);
      check("rst_ready", req_ready, 0);

      // up from 3, 4 steps
      issue(0, 1, 3, 4, w);
      check("t1_ready_cycle0", w, 0);
      wait_done(id, cnt, nb);
      check("t1_id", id, 0);
      check("t1_count", cnt, 7);
      check("t1_busy_cycles", nb, 6);

      // wrap up through 15->0, then wrap down through 0->15
      issue(1, 1, 14, 3, w);
      wait_done(id, cnt, nb);
      check("t2_id", id, 1);
      check("t2_count", cnt, 1);
      check("t2_busy_cycles", nb, 5);
      issue(1, 0, 1, 3, w);
      wait_done(id, cnt, nb);
      check("t2_down_count", cnt, 14);

      // zero steps: load then immediate completion
      issue(0, 1, 9, 0, w);
      wait_done(id, cnt, nb);
      check("t4_count", cnt, 9);
      check("t4_busy_cycles", nb, 2);

      // pause for three cycles mid-run
      issue(0, 1, 0, 5, w);
      @(posedge clk); #1;
      @(posedge clk); #1 pause = 1;
      repeat (3) @(posedge clk);
      #1 pause = 0;
      check("t5_frozen_count", count, 1);
      wait_done(id, cnt, nb);
      check("t5_count", cnt, 5);
      check("t5_busy_cycles", nb, 10);

      // reset aborts a run, then a new request is accepted at once
      issue(0, 1, 0, 10, w);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (count == 4'd6) break;
      end
      check("t6_count_before_rst", count, 6);
      rst = 1;
      @(posedge clk); #1;
      check("t6_rst_count", count, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      rst = 0;
      issue(1, 1, 2, 1, w);
      check("t6_accept_immediate", w, 0);
      wait_done(id, cnt, nb);
      check("t6_id", id, 1);
      check("t6_count", cnt, 3);

      // both held valid from reset: service alternates starting with 0
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      req_dir = 2'b11; req_start = {4'd8, 4'd4}; req_steps = {4'd1, 4'd1};
      req_valid = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_done(id, cnt, nb);
         order[n] = id;
      end
      @(posedge clk); #1 req_valid = 2'b00;
      check("t3_order0", order[0], 0);
      check("t3_order1", order[1], 1);
      check("t3_order2", order[2], 0);
      check("t3_order3", order[3], 1);
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
